// File: rtl/instr_dispatch_fsm_pkg.sv
// Shared definitions for the instruction dispatch controller: opcode map,
// error codes and the dispatch state encoding.
package instr_dispatch_fsm_pkg;

  localparam logic [3:0] OP_ALU_MAX = 4'd7;
  localparam logic [3:0] OP_MOVI    = 4'd9;
  localparam logic [3:0] OP_MOV     = 4'd10;
  localparam logic [3:0] OP_HALT    = 4'd15;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StLoad,
    StDecode,
    StStart,
    StWaitDone,
    StAdvance,
    StHalted,
    StError
  } dispatch_state_e;

  typedef enum logic [1:0] {
    ClsAlu,
    ClsMov,
    ClsHalt,
    ClsIllegal
  } op_class_e;

  function automatic op_class_e decode_op(input logic [3:0] op);
    op_class_e cls;
    if (op <= OP_ALU_MAX) begin
      cls = ClsAlu;
    end else if (op == OP_MOVI || op == OP_MOV) begin
      cls = ClsMov;
    end else if (op == OP_HALT) begin
      cls = ClsHalt;
    end else begin
      cls = ClsIllegal;
    end
    return cls;
  endfunction

endpackage

// File: rtl/instr_dispatch_fsm_if.sv
// Bus between the dispatch controller, program memory and execution units.
// master = dispatch controller, slave = surrounding core / memory / units.
interface instr_dispatch_fsm_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               run;
  logic [PC_W-1:0]    pmem_addr;
  logic               pmem_rd_en;
  logic [INSTR_W-1:0] pmem_data;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         opcode;
  logic               mov_str;
  logic               alu_str;
  logic               ex_done;
  logic [PC_W-1:0]    pc;
  logic               busy;
  logic               halted;
  logic               err;
  logic [1:0]         err_code;
  logic [15:0]        instr_count;

  modport master (
    input  run, pmem_data, ex_done,
    output pmem_addr, pmem_rd_en, ir, opcode, mov_str, alu_str, pc, busy, halted, err,
           err_code, instr_count
  );

  modport slave (
    output run, pmem_data, ex_done,
    input  pmem_addr, pmem_rd_en, ir, opcode, mov_str, alu_str, pc, busy, halted, err,
           err_code, instr_count
  );
endinterface

// File: rtl/instr_dispatch_fsm_timeout_ctr.sv
// Cycle counter for the WAIT_DONE state; saturates at TIMEOUT-1 and flags expiry.
module dispatch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/instr_dispatch_fsm.sv
// Fetch/decode/dispatch controller: fetches an instruction, strobes the matching
// execution unit and waits for its done flag before advancing the PC.
module instr_dispatch_fsm
  import instr_dispatch_fsm_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_dispatch_fsm_if.master bus
);
  dispatch_state_e    r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_rd_en;
  logic               r_mov_str;
  logic               r_alu_str;
  logic               r_busy;
  logic               r_halted;
  logic               r_err;
  logic [1:0]         r_err_code;
  logic [15:0]        r_instr_count;

  logic       w_tmo_clr;
  logic       w_tmo_en;
  logic       w_tmo_expired;
  logic [3:0] w_opcode;

  assign w_opcode  = r_ir[INSTR_W-1 -: 4];
  assign w_tmo_clr = (r_state == StStart);
  assign w_tmo_en  = (r_state == StWaitDone);

  dispatch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_tmo_clr),
    .i_en      (w_tmo_en),
    .o_expired (w_tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_pc          <= '0;
      r_ir          <= '0;
      r_rd_en       <= 1'b0;
      r_mov_str     <= 1'b0;
      r_alu_str     <= 1'b0;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_instr_count <= '0;
    end else begin
      // Strobes are single-cycle; only the entering transition raises them.
      r_rd_en   <= 1'b0;
      r_mov_str <= 1'b0;
      r_alu_str <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.run) begin
            r_state <= StFetch;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        StFetch: r_state <= StLoad;
        StLoad: begin
          r_ir    <= bus.pmem_data;
          r_state <= StDecode;
        end
        StDecode: begin
          unique case (decode_op(w_opcode))
            ClsMov: begin
              r_state   <= StStart;
              r_mov_str <= 1'b1;
            end
            ClsAlu: begin
              r_state   <= StStart;
              r_alu_str <= 1'b1;
            end
            ClsHalt: begin
              r_state  <= StHalted;
              r_halted <= 1'b1;
              r_busy   <= 1'b0;
            end
            ClsIllegal: begin
              r_state    <= StError;
              r_err      <= 1'b1;
              r_err_code <= ERR_ILLEGAL;
              r_busy     <= 1'b0;
            end
          endcase
        end
        StStart: r_state <= StWaitDone;
        StWaitDone: begin
          // A done arriving on the last allowed cycle still wins over the timeout.
          if (bus.ex_done) begin
            r_state <= StAdvance;
          end else if (w_tmo_expired) begin
            r_state    <= StError;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_busy     <= 1'b0;
          end
        end
        StAdvance: begin
          r_pc          <= r_pc + PC_W'(1);
          r_instr_count <= r_instr_count + 16'd1;
          if (bus.run) begin
            r_state <= StFetch;
            r_rd_en <= 1'b1;
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        StHalted: r_state <= StHalted;
        StError:  r_state <= StError;
        default: begin
          r_state <= StError;
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pmem_addr   = r_pc;
  assign bus.pmem_rd_en  = r_rd_en;
  assign bus.ir          = r_ir;
  assign bus.opcode      = w_opcode;
  assign bus.mov_str     = r_mov_str;
  assign bus.alu_str     = r_alu_str;
  assign bus.pc          = r_pc;
  assign bus.busy        = r_busy;
  assign bus.halted      = r_halted;
  assign bus.err         = r_err;
  assign bus.err_code    = r_err_code;
  assign bus.instr_count = r_instr_count;
endmodule

// File: doc/instr_dispatch_fsm.md
Name: instr_dispatch_fsm

Overview:
Instruction fetch/dispatch controller: the initiator side of the execution-unit start/done handshake. It fetches a word from program memory, decodes the 4-bit opcode and issues a one-cycle start strobe to the matching execution FSM (MOV unit or ALU unit). It then waits for that unit's done flag before advancing the PC. It sits between program memory and the per-class execution FSMs in the microcontroller core.

Parameters:
PC_W, 8, program counter / program memory address width
INSTR_W, 16, instruction width; opcode is ir[INSTR_W-1 -: 4]
TIMEOUT, 64, max cycles in WAIT_DONE before error (must be >= 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; 1 = fetch/execute, 0 = stop at next instruction boundary
pmem_addr  out  PC_W  program memory address
pmem_rd_en  out  1  program memory read strobe
pmem_data  in  INSTR_W  read data, valid one cycle after pmem_rd_en
ir  out  INSTR_W  current instruction register (fields to decoders)
opcode  out  4  ir opcode field
mov_str  out  1  start strobe to MOV FSM (opcodes 9 MOVI, 10 MOV)
alu_str  out  1  start strobe to ALU FSM (opcodes 0..7)
ex_done  in  1  done flag from execution units; only 1'b1 counts (0/z/x = not done)
pc  out  PC_W  program counter
busy  out  1  1 in any state except IDLE/HALTED/ERROR
halted  out  1  HALT (opcode 15) executed
err  out  1  sticky error
err_code  out  2  0 none, 1 illegal opcode, 2 done timeout
instr_count  out  16  retired instructions, wraps at 2^16

Behaviour:
- Synchronous, active-high reset (sampled on rising clk): state=IDLE, pc=0, ir=0, all strobes 0, busy=0, halted=0, err=0, err_code=0, instr_count=0, timeout counter=0. A reset in any state, including mid-handshake, aborts with no further strobes.
- States: IDLE, FETCH, LOAD, DECODE, START, WAIT_DONE, ADVANCE, HALTED, ERROR.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: pmem_rd_en=1, pmem_addr=pc (pmem_addr tracks pc in all states). -> LOAD.
- LOAD: ir <= pmem_data. -> DECODE.
- DECODE: opcode 9/10 -> START(mov); 0..7 -> START(alu); 15 -> HALTED; 8, 11..14 -> ERROR with err_code=1.
- START: exactly one of mov_str/alu_str =1 for exactly one cycle; timeout counter cleared. -> WAIT_DONE.
- WAIT_DONE: strobes 0; counter++ each cycle. ex_done==1'b1 -> ADVANCE. ex_done has priority if it arrives in the same cycle the counter reaches TIMEOUT-1. Otherwise the counter reaching TIMEOUT-1 -> ERROR with err_code=2.
- ADVANCE: pc <= pc+1 mod 2^PC_W (wraps 2^PC_W-1 -> 0); instr_count++. run=1 -> FETCH, else -> IDLE.
- HALTED: halted=1; pc not incremented; instr_count not incremented; remains until reset.
- ERROR: err=1, err_code held; remains until reset.
- ex_done is ignored outside WAIT_DONE.
- run dropping mid-instruction does not abort; it is only checked in IDLE and ADVANCE.
- Minimum instruction latency: FETCH..ADVANCE = 6 cycles when ex_done returns 1 cycle after the strobe.
- ir/opcode remain stable from LOAD+1 until the next LOAD.

Decomposition:
- Shared package mcu_pkg: opcode constants (OP_MOVI=9, OP_MOV=10, OP_HALT=15, ALU range 0..7), err_code constants, dispatch state encoding.
- One natural sub-module: dispatch_timeout_ctr (clear/enable/expired, TIMEOUT-parameterised).

Test Plan:
- Reset, run=1, pmem[0]=16'hA123 (MOV), ex_done pulses 3 cycles after mov_str -> single mov_str pulse, alu_str=0, pc 0->1, instr_count=1.
- pmem[0..2]={9xxx, 3xxx, Fxxx}, done 1 cycle after each strobe -> mov_str then alu_str pulses; halted=1 with pc=2 and instr_count=2; no further pmem_rd_en.
- pmem[0]=16'h8000 -> err=1, err_code=1, no strobe, busy=0; stays until reset.
- MOV with ex_done held 0/z -> err_code=2 exactly TIMEOUT cycles after entering WAIT_DONE. Variant: done on the final cycle -> ADVANCE, no error.
- PC_W=2, four non-halt instructions with run=1 -> pc wraps 3->0 and refetches addr 0. run deasserted during WAIT_DONE -> instruction completes, then IDLE.
- Reset asserted during WAIT_DONE -> next cycle all outputs at reset values; late ex_done ignored.
